// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// wb_stage : RV32E writeback stage - load alignment, fault flags, retire count
// Rev 1.0
// ============================================================================
module wb_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [4:0]      ex_rd_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic            ex_is_load_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            write_enable_o,
  output logic [4:0]      write_address_o,
  output logic [XLEN-1:0] write_data_o,
  output logic            fwd_valid_o,
  output logic [4:0]      fwd_rd_o,
  output logic [XLEN-1:0] fwd_data_o,
  output logic            misalign_o,
  output logic            illegal_o,
  output logic [31:0]     instret_o
);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  localparam logic [5:0] C_NUM_REGS = 6'(NUM_REGS);

  state_t          r_state;
  logic [4:0]      r_ld_rd;
  logic [1:0]      r_ld_addr;
  logic [2:0]      r_ld_funct3;
  logic            r_we;
  logic [4:0]      r_waddr;
  logic [XLEN-1:0] r_wdata;
  logic            r_misalign;
  logic            r_illegal;
  logic [31:0]     r_instret;

  logic            w_accept;
  logic            w_nl_done;
  logic            w_ld_done;
  logic            w_done;
  logic [4:0]      w_rd;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_misalign;
  logic            w_f3_illegal;
  logic            w_illegal;
  logic            w_misalign;
  logic [XLEN-1:0] w_data;

  assign ex_ready_o = (r_state == S_IDLE);
  assign w_accept   = ex_valid_i && ex_ready_o;
  assign w_nl_done  = w_accept && !ex_is_load_i;
  assign w_ld_done  = (r_state == S_WAIT_MEM) && mem_rvalid_i;
  assign w_done     = w_nl_done || w_ld_done;
  assign w_rd       = w_ld_done ? r_ld_rd : ex_rd_i;

  // Lane select, extension and fault decode for the pending load
  always_comb begin
    w_byte = mem_rdata_i[7:0];
    case (r_ld_addr)
      2'd1:    w_byte = mem_rdata_i[15:8];
      2'd2:    w_byte = mem_rdata_i[23:16];
      2'd3:    w_byte = mem_rdata_i[31:24];
      default: w_byte = mem_rdata_i[7:0];
    endcase
    w_half        = r_ld_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    w_ld_data     = mem_rdata_i;
    w_ld_misalign = 1'b0;
    w_f3_illegal  = 1'b0;
    case (r_ld_funct3)
      3'b000: w_ld_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001: begin
        w_ld_data     = {{(XLEN-16){w_half[15]}}, w_half};
        w_ld_misalign = r_ld_addr[0];
      end
      3'b010: w_ld_misalign = |r_ld_addr;
      3'b100: w_ld_data = {{(XLEN-8){1'b0}}, w_byte};
      3'b101: begin
        w_ld_data     = {{(XLEN-16){1'b0}}, w_half};
        w_ld_misalign = r_ld_addr[0];
      end
      default: w_f3_illegal = 1'b1;
    endcase
  end

  assign w_illegal  = ({1'b0, w_rd} >= C_NUM_REGS) || (w_ld_done && w_f3_illegal);
  assign w_misalign = w_ld_done && w_ld_misalign && !w_illegal;
  assign w_data     = w_ld_done ? w_ld_data : ex_result_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ld_rd     <= 5'd0;
      r_ld_addr   <= 2'd0;
      r_ld_funct3 <= 3'd0;
      r_we        <= 1'b0;
      r_waddr     <= 5'd0;
      r_wdata     <= '0;
      r_misalign  <= 1'b0;
      r_illegal   <= 1'b0;
      r_instret   <= 32'd0;
    end else begin
      r_we       <= 1'b0;
      r_misalign <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept && ex_is_load_i) begin
            r_ld_rd     <= ex_rd_i;
            r_ld_addr   <= ex_result_i[1:0];
            r_ld_funct3 <= ex_funct3_i;
            r_state     <= S_WAIT_MEM;
          end
        end
        S_WAIT_MEM: begin
          if (mem_rvalid_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // Faulting completions leave the write port and retire count untouched
      if (w_done) begin
        if (w_illegal) begin
          r_illegal <= 1'b1;
        end else if (w_misalign) begin
          r_misalign <= 1'b1;
        end else begin
          r_we      <= (w_rd != 5'd0);
          r_waddr   <= w_rd;
          r_wdata   <= w_data;
          r_instret <= r_instret + 32'd1;
        end
      end
    end
  end

  assign write_enable_o  = r_we;
  assign write_address_o = r_waddr;
  assign write_data_o    = r_wdata;
  assign fwd_valid_o     = r_we;
  assign fwd_rd_o        = r_waddr;
  assign fwd_data_o      = r_wdata;
  assign misalign_o      = r_misalign;
  assign illegal_o       = r_illegal;
  assign instret_o       = r_instret;

endmodule
`default_nettype wire
